// File: rtl/moka_run_ctrl.sv
// rtl/moka_run_ctrl.sv - run/halt sequencer gating the moka RV32 core enable
// Optional PC breakpoint halt is built when MOKA_RUN_CTRL_BP_EN is defined.
module moka_run_ctrl #(
  parameter int CNT_W     = 16,
  parameter bit RESET_RUN = 1'b0,
  parameter int XLEN      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             core_en,
  output logic             halted,
  output logic             done,
  output logic             cmd_err,
  output logic [1:0]       halt_cause,
  output logic [31:0]      cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_RUN_N  = 2'd3
  } state_e;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RUN_N = 2'd3;

  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_DONE = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [31:0]      cycle_cnt_q;
  logic [1:0]       halt_cause_q;
  logic             done_q;
  logic             cmd_err_q;
  logic             first_q;

  logic             accept;
  logic             bp_hit;
  logic [31:0]      cycle_cnt_d;

  assign accept = en && cmd_valid;

`ifdef MOKA_RUN_CTRL_BP_EN
  // first_q lets a resumed RUN execute the instruction sitting on the breakpoint.
  assign bp_hit = bp_valid && (pc_in == bp_addr) && !first_q &&
                  ((state_q == S_RUN) || (state_q == S_RUN_N));
`else
  logic unused_bp;
  assign unused_bp = ^{pc_in, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  assign core_en     = en && (state_q != S_HALTED) && !bp_hit;
  assign cycle_cnt_d = core_en ? cycle_cnt_q + 32'd1 : cycle_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RESET_RUN ? S_RUN : S_HALTED;
      remaining_q  <= '0;
      cycle_cnt_q  <= '0;
      halt_cause_q <= '0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      first_q      <= 1'b1;
    end else if (!en) begin
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      cycle_cnt_q <= cycle_cnt_d;
      if (state_q == S_HALTED) begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_q <= S_RUN;
              first_q <= 1'b1;
            end
            OP_STEP: begin
              state_q <= S_STEP;
              first_q <= 1'b1;
            end
            OP_RUN_N: begin
              if (cmd_count != '0) begin
                state_q     <= S_RUN_N;
                remaining_q <= cmd_count;
                first_q     <= 1'b1;
              end else begin
                done_q       <= 1'b1;
                halt_cause_q <= CAUSE_DONE;
              end
            end
            default: ;
          endcase
        end
      end else begin
        first_q <= 1'b0;
        if (accept && (cmd_op == OP_HALT)) begin
          state_q      <= S_HALTED;
          done_q       <= 1'b1;
          halt_cause_q <= CAUSE_CMD;
          remaining_q  <= '0;
        end else begin
          if (accept) begin
            cmd_err_q <= 1'b1;
          end
          if (bp_hit) begin
            state_q      <= S_HALTED;
            done_q       <= 1'b1;
            halt_cause_q <= CAUSE_BP;
            remaining_q  <= '0;
          end else if (state_q == S_STEP) begin
            state_q      <= S_HALTED;
            done_q       <= 1'b1;
            halt_cause_q <= CAUSE_DONE;
          end else if (state_q == S_RUN_N) begin
            remaining_q <= remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
              state_q      <= S_HALTED;
              done_q       <= 1'b1;
              halt_cause_q <= CAUSE_DONE;
            end
          end
        end
      end
    end
  end

  assign cmd_ready  = en;
  assign halted     = (state_q == S_HALTED);
  assign done       = done_q;
  assign cmd_err    = cmd_err_q;
  assign halt_cause = halt_cause_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_moka_run_ctrl.sv
// tb/tb_moka_run_ctrl.sv - scoreboard bench for moka_run_ctrl
module tb_moka_run_ctrl;
  localparam int CNT_W = 16;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rstn, en, cmd_valid, bp_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [XLEN-1:0]  pc, bp_addr;
  logic             cmd_ready, core_en, halted, done, cmd_err;
  logic [1:0]       halt_cause;
  logic [31:0]      cycle_cnt;
  logic             pc_clr;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ce_count = 0;
  int   ce_base;

  moka_run_ctrl #(.CNT_W(CNT_W), .RESET_RUN(1'b0), .XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .pc_in(pc), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .core_en(core_en), .halted(halted), .done(done),
    .cmd_err(cmd_err), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Minimal core model: PC advances by 4 per executed instruction.
  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (core_en) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_en) ce_count++;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("done_cause", {30'd0, halt_cause}, {30'd0, sb_e.cause});
        check("done_cnt", cycle_cnt, sb_e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] cause, input logic [31:0] cnt);
    exp_t e;
    e.cause = cause;
    e.cnt   = cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int i = 0;
    while (!halted && i < budget) begin
      tick();
      i++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = '0;
    bp_addr = '0; bp_valid = 1'b0; pc_clr = 1'b1;
    repeat (2) tick();
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_core_en", {31'd0, core_en}, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_cause", {30'd0, halt_cause}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rstn = 1'b1; pc_clr = 1'b0;
    repeat (2) tick();

    // RUN then HALT ten edges later
    ce_base = ce_count;
    send(2'd1, '0);
    repeat (9) tick();
    check("t1_running", {31'd0, halted}, 32'd0);
    push(2'd1, 32'd10);
    send(2'd0, '0);
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_done", {31'd0, done}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_ce_cycles", ce_count - ce_base, 32'd10);

    // RUN_N 5, then RUN_N 0
    ce_base = ce_count;
    push(2'd2, 32'd15);
    send(2'd3, 16'd5);
    repeat (4) tick();
    check("t2_still_running", {31'd0, halted}, 32'd0);
    tick();
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_ce_cycles", ce_count - ce_base, 32'd5);
    tick();
    ce_base = ce_count;
    push(2'd2, 32'd15);
    send(2'd3, 16'd0);
    check("t2_n0_done", {31'd0, done}, 32'd1);
    check("t2_n0_halted", {31'd0, halted}, 32'd1);
    tick();
    check("t2_n0_ce", ce_count - ce_base, 32'd0);

    // three STEPs with gaps
    ce_base = ce_count;
    for (int i = 0; i < 3; i++) begin
      push(2'd2, 32'd16 + i);
      send(2'd2, '0);
      check("t3_step_en", {31'd0, core_en}, 32'd1);
      tick();
      check("t3_step_off", {31'd0, core_en}, 32'd0);
      repeat (3) tick();
    end
    check("t3_cycle_cnt", cycle_cnt, 32'd18);
    check("t3_cause", {30'd0, halt_cause}, 32'd2);
    check("t3_ce_cycles", ce_count - ce_base, 32'd3);

    // STEP while running is rejected
    send(2'd1, '0);
    send(2'd2, '0);
    check("t3_cmd_err", {31'd0, cmd_err}, 32'd1);
    check("t3_busy_run", {31'd0, halted}, 32'd0);
    tick();
    check("t3_cmd_err_pulse", {31'd0, cmd_err}, 32'd0);
    repeat (7) tick();
    push(2'd1, 32'd28);
    send(2'd0, '0);
    tick();

    // RUN_N 8 with en low for four cycles
    ce_base = ce_count;
    push(2'd2, 32'd36);
    send(2'd3, 16'd8);
    repeat (3) tick();
    en = 1'b0;
    #1;
    check("t4_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("t4_core_en_low", {31'd0, core_en}, 32'd0);
    send(2'd0, '0);
    repeat (3) tick();
    check("t4_cnt_frozen", cycle_cnt, 32'd31);
    check("t4_state_held", {31'd0, halted}, 32'd0);
    en = 1'b1;
    #1;
    check("t4_resume", {31'd0, core_en}, 32'd1);
    wait_halted("t4_wait_halt", 20);
    check("t4_ce_cycles", ce_count - ce_base, 32'd8);
    tick();

    // breakpoint at 0x10, PC from 0
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
    bp_addr = 32'h10;
    bp_valid = 1'b1;
`ifdef MOKA_RUN_CTRL_BP_EN
    push(2'd3, 32'd40);
    send(2'd1, '0);
    wait_halted("t5_bp_wait", 20);
    check("t5_bp_pc", pc, 32'h10);
    check("t5_bp_cause", {30'd0, halt_cause}, 32'd3);
    check("t5_bp_cnt", cycle_cnt, 32'd40);
    tick();
    send(2'd1, '0);
    tick();
    check("t5_resume_pc", pc, 32'h14);
    check("t5_resume_run", {31'd0, halted}, 32'd0);
`else
    send(2'd1, '0);
    repeat (8) tick();
    check("t5_no_bp_run", {31'd0, halted}, 32'd0);
    check("t5_no_bp_pc", pc, 32'h20);
`endif
    repeat (2) tick();
    rstn = 1'b0;
    #2;
    check("t5_rst_halted", {31'd0, halted}, 32'd1);
    check("t5_rst_core_en", {31'd0, core_en}, 32'd0);
    check("t5_rst_cnt", cycle_cnt, 32'd0);
    check("t5_rst_cause", {30'd0, halt_cause}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("t5_stay_halted", {31'd0, halted}, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/moka_run_ctrl.md
Name: moka_run_ctrl

Overview:
- Run/halt sequencer for the moka RV32 single-cycle core.
- Sits between the top-level enable and the core's `en` input, and gates core execution cycle by cycle.
- Accepts host commands: HALT, RUN, STEP, RUN_N (run for N cycles).
- Counts executed cycles and reports why the core stopped.

Parameters:
CNT_W, 16, width of the RUN_N cycle count and of the remaining-cycle counter
RESET_RUN, 0, 1 = enter RUN state on reset release (free-running core); 0 = enter HALTED
XLEN, 32, width of the pc_in and bp_addr compare

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state and forces core_en=0
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accept (= en)
cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=RUN_N
cmd_count  in  CNT_W  cycle count for RUN_N
pc_in  in  XLEN  current core PC (used by the breakpoint)
bp_addr  in  XLEN  breakpoint address (static configuration)
bp_valid  in  1  breakpoint armed
core_en  out  1  drives core `en`; core executes one instruction per cycle while high
halted  out  1  state == HALTED
done  out  1  one-cycle pulse when the controller enters HALTED
cmd_err  out  1  one-cycle pulse when a non-HALT command arrives while busy
halt_cause  out  2  0=reset, 1=HALT command, 2=STEP/RUN_N complete, 3=breakpoint
cycle_cnt  out  32  count of cycles with core_en=1; wraps 0xFFFFFFFF->0

Behaviour:
- Reset (async, rstn=0):
  - State = RUN if RESET_RUN=1, else HALTED.
  - remaining=0, cycle_cnt=0, halt_cause=0, done=0, cmd_err=0, first=1.
  - Reset mid-operation aborts immediately; no done pulse.
- States: HALTED, RUN, STEP, RUN_N.
- Command handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. No buffering; one command per cycle.
- Decisions are taken at each edge where en=1. When en=0, state, counters and pulses are held at 0/unchanged, commands are not accepted, and core_en=0.
- core_en = en && state!=HALTED && !bp_hit. This is combinational from registered state, en and bp_hit.
- HALTED transitions:
  - RUN -> RUN.
  - STEP -> STEP.
  - RUN_N with count>0 -> RUN_N, remaining=count.
  - RUN_N with count=0 -> stay HALTED; done=1, halt_cause=2.
  - HALT -> stay HALTED; no done pulse.
  - Leaving HALTED sets first=1.
- STEP: core_en high for exactly one enabled cycle, then HALTED. done=1 in the first HALTED cycle, halt_cause=2.
- RUN_N:
  - remaining decrements on each enabled cycle.
  - An enabled cycle with remaining==1 moves to HALTED, so core_en is high for exactly N enabled cycles.
  - done=1, halt_cause=2.
- RUN: runs until a HALT command or a breakpoint.
- HALT in RUN, STEP or RUN_N:
  - HALTED on the next edge; core_en is still high in the accept cycle.
  - done=1, halt_cause=1, remaining cleared.
  - HALT has priority over STEP/RUN_N completion in the same cycle.
- Busy + non-HALT command: command is dropped, state unchanged, cmd_err=1 for one cycle.
- first flag: cleared after the first enabled cycle outside HALTED.
- cycle_cnt: +1 on each edge where core_en=1. Wraps modulo 2^32.
- done and cmd_err are registered pulses, never high for two consecutive cycles from a single event.

Optional Feature:
- Macro: MOKA_RUN_CTRL_BP_EN.
- Defined:
  - bp_hit = bp_valid && pc_in==bp_addr && state in {RUN, RUN_N} && !first.
  - On bp_hit, core_en=0 in that cycle, so the instruction at bp_addr is not executed and not counted.
  - Next state HALTED, done=1, halt_cause=3.
  - An explicit HALT in the same cycle wins (halt_cause=1).
  - The first rule lets RUN resume past the breakpoint.
  - STEP ignores breakpoints.
- Not defined: bp_hit=0; bp_addr and bp_valid are unused; halt_cause never equals 3.

Test Plan:
- Reset release with RESET_RUN=0, then RUN at cycle 3 and HALT at cycle 13 -> core_en high for exactly 10 cycles; cycle_cnt=10; done pulse once; halt_cause=1.
- RUN_N with count=5 from HALTED -> core_en high 5 consecutive cycles; done one cycle after; cycle_cnt=5; RUN_N with count=0 -> done immediately, core_en never high.
- STEP issued 3 times with gaps -> three single-cycle core_en pulses; cycle_cnt=3; halt_cause=2. STEP sent while in RUN -> cmd_err pulse, still running.
- RUN_N count=8 with en dropped for 4 cycles mid-run -> core_en low while en=0; remaining frozen; total core_en cycles = 8.
- With BP_EN, bp_addr=0x00000010, PC incrementing by 4 from 0 -> halt with PC=0x10, cycle_cnt=4, halt_cause=3. A following RUN executes the instruction at 0x10 (no re-hit). Then rstn pulse mid-run -> immediate HALTED, all outputs 0.
